// File: rtl/pixel_pkg.sv
// Shared types and defaults for the pixel combinator (read side of the reorder queues).
package pixel_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, WAIT} comb_state_t;

  localparam logic [23:0] DEF_FILL_COLOUR = 24'hFF00FF;
  localparam int          DEF_FRAME_W     = 640;
  localparam int          DEF_FRAME_H     = 480;
endpackage

// File: rtl/pixel_combinator_if.sv
// Coordinate broadcast to the engine queues plus the ordered pixel stream to the display writer.
interface pixel_combinator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RBG_SIZE   = 24,
  parameter int NUM_LANES  = 4
) ();
  logic [DATA_WIDTH-1:0]                xpixel_check;
  logic [DATA_WIDTH-1:0]                ypixel_check;
  logic                                 check_valid;
  logic [NUM_LANES-1:0]                 lane_hit;
  logic [NUM_LANES-1:0][RBG_SIZE-1:0]   lane_colour;
  logic                                 pix_valid;
  logic                                 pix_ready;
  logic [RBG_SIZE-1:0]                  pix_colour;
  logic                                 pix_sof;
  logic                                 pix_eol;

  modport master (
    output xpixel_check, ypixel_check, check_valid, pix_valid, pix_colour, pix_sof, pix_eol,
    input  lane_hit, lane_colour, pix_ready
  );
  modport slave (
    input  xpixel_check, ypixel_check, check_valid, pix_valid, pix_colour, pix_sof, pix_eol,
    output lane_hit, lane_colour, pix_ready
  );
endinterface

// File: rtl/pixel_combinator_raster_counter.sv
// Raster-order x/y walker; advances one pixel per accept and wraps at frame end.
module raster_counter #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  sof,
  output logic                  eol,
  output logic                  last
);
  assign sof  = (x == '0) && (y == '0);
  assign eol  = (x == DATA_WIDTH'(FRAME_W - 1));
  assign last = eol && (y == DATA_WIDTH'(FRAME_H - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (eol) begin
        x <= '0;
        y <= last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pixel_combinator.sv
// Walks the frame in raster order, collects each pixel from whichever queue holds it and emits
// an ordered valid/ready stream; missing pixels are filled after TIMEOUT cycles of searching.
module pixel_combinator
  import pixel_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          RBG_SIZE    = 24,
  parameter int          NUM_LANES   = 4,
  parameter int          FRAME_W     = DEF_FRAME_W,
  parameter int          FRAME_H     = DEF_FRAME_H,
  parameter int          TIMEOUT     = 1024,
  parameter logic [RBG_SIZE-1:0] FILL_COLOUR = RBG_SIZE'(DEF_FILL_COLOUR)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  pixel_combinator_if.master  bus,
  output logic                frame_done,
  output logic [15:0]         drop_count,
  output logic                err_multi_hit
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  comb_state_t          state;
  logic [TW-1:0]        tcnt;
  logic                 check_valid, pix_valid, pix_sof, pix_eol;
  logic [RBG_SIZE-1:0]  pix_colour, hit_colour;
  logic                 hit_any, multi, timed_out, accept;
  logic                 r_sof, r_eol, r_last;

  raster_counter #(.DATA_WIDTH(DATA_WIDTH), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H)) u_raster (
    .clk(clk), .reset(reset), .advance(accept),
    .x(bus.xpixel_check), .y(bus.ypixel_check),
    .sof(r_sof), .eol(r_eol), .last(r_last)
  );

  // Descending scan so the lowest-index set lane wins.
  always_comb begin
    hit_colour = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (bus.lane_hit[i]) hit_colour = bus.lane_colour[i];
  end

  assign hit_any   = |bus.lane_hit;
  assign multi     = (bus.lane_hit & (bus.lane_hit - 1'b1)) != '0;
  assign timed_out = (TIMEOUT != 0) && (tcnt == T_LAST);
  assign accept    = (state == WAIT) && bus.pix_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      tcnt          <= '0;
      check_valid   <= 1'b0;
      pix_valid     <= 1'b0;
      pix_colour    <= '0;
      pix_sof       <= 1'b0;
      pix_eol       <= 1'b0;
      frame_done    <= 1'b0;
      drop_count    <= '0;
      err_multi_hit <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (hit_any && ((state != SCAN) || multi)) err_multi_hit <= 1'b1;
      case (state)
        IDLE: if (run) begin
          state       <= SCAN;
          check_valid <= 1'b1;
          tcnt        <= '0;
        end
        SCAN: begin
          tcnt <= tcnt + 1'b1;
          if (hit_any || timed_out) begin
            pix_colour  <= hit_any ? hit_colour : FILL_COLOUR;
            pix_sof     <= r_sof;
            pix_eol     <= r_eol;
            pix_valid   <= 1'b1;
            check_valid <= 1'b0;
            state       <= WAIT;
            if (!hit_any && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
          end
        end
        WAIT: if (bus.pix_ready) begin
          pix_valid <= 1'b0;
          tcnt      <= '0;
          // run is only honoured at the frame boundary.
          if (r_last && !run) begin
            state       <= IDLE;
            check_valid <= 1'b0;
          end else begin
            state       <= SCAN;
            check_valid <= 1'b1;
          end
          if (r_last) frame_done <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          check_valid <= 1'b0;
          pix_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.check_valid = check_valid;
  assign bus.pix_valid   = pix_valid;
  assign bus.pix_colour  = pix_colour;
  assign bus.pix_sof     = pix_sof;
  assign bus.pix_eol     = pix_eol;
endmodule

// File: tb/tb_pixel_combinator.sv
// Directed bench for pixel_combinator on a 4x2 frame with an 8-cycle timeout.
module tb_pixel_combinator;
  localparam int DW = 32, RS = 24, NL = 4, FW = 4, FH = 2, TO = 8;
  localparam logic [23:0] FILL = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        reset, run;
  logic        frame_done;
  logic [15:0] drop_count;
  logic        err_multi_hit;
  int          checks = 0, errors = 0, fd_cnt = 0;

  pixel_combinator_if #(.DATA_WIDTH(DW), .RBG_SIZE(RS), .NUM_LANES(NL)) bus ();

  pixel_combinator #(
    .DATA_WIDTH(DW), .RBG_SIZE(RS), .NUM_LANES(NL), .FRAME_W(FW), .FRAME_H(FH),
    .TIMEOUT(TO), .FILL_COLOUR(FILL)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .bus(bus),
    .frame_done(frame_done), .drop_count(drop_count), .err_multi_hit(err_multi_hit)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_cv(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.check_valid === 1'b1) begin ok = 1'b1; break; end
      step();
    end
  endtask

  // Queue model: lane_hit arrives the cycle after the match; lane i returns {i, c[15:0]}.
  task automatic answer(input logic [3:0] hit, input logic [23:0] c);
    step();
    bus.lane_hit = hit;
    for (int i = 0; i < NL; i++) bus.lane_colour[i] = {8'(i), c[15:0]};
    step();
    bus.lane_hit = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; bus.pix_ready = 1'b0; bus.lane_hit = '0; bus.lane_colour = '0;
    step(); step();
    checks++;
    if (bus.check_valid !== 1'b0 || bus.pix_valid !== 1'b0 || bus.pix_colour !== 24'h0 ||
        bus.pix_sof !== 1'b0 || bus.pix_eol !== 1'b0 || frame_done !== 1'b0 ||
        drop_count !== 16'h0 || err_multi_hit !== 1'b0 || bus.xpixel_check !== 32'd0 ||
        bus.ypixel_check !== 32'd0)
      begin errors++; $display("FAIL reset_state cv=%b pv=%b col=%h drop=%0d err=%b", bus.check_valid,
        bus.pix_valid, bus.pix_colour, drop_count, err_multi_hit); end
    reset = 1'b1;
    step(); step(); step();
    checks++;
    if (bus.check_valid !== 1'b0) begin errors++; $display("FAIL idle_no_run cv=%b want 0", bus.check_valid); end
  endtask

  task automatic test_in_order();
    bit ok;
    logic [23:0] exp;
    run = 1'b1; bus.pix_ready = 1'b1;
    for (int p = 0; p < 8; p++) begin
      wait_cv(ok);
      checks++;
      if (!ok || bus.xpixel_check !== 32'(p % 4) || bus.ypixel_check !== 32'(p / 4))
        begin errors++; $display("FAIL inorder_coord p=%0d got (%0d,%0d) want (%0d,%0d)", p,
          bus.xpixel_check, bus.ypixel_check, p % 4, p / 4); end
      answer(4'b0001 << (p % 4), {8'h00, 8'(8'h10 + p), 8'h3C});
      exp = {8'(p % 4), 8'(8'h10 + p), 8'h3C};
      checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_colour !== exp || bus.pix_sof !== (p == 0) ||
          bus.pix_eol !== (p % 4 == 3))
        begin errors++; $display("FAIL inorder_pixel p=%0d pv=%b col=%h sof=%b eol=%b want col=%h", p,
          bus.pix_valid, bus.pix_colour, bus.pix_sof, bus.pix_eol, exp); end
      step();
      checks++;
      if (frame_done !== (p == 7))
        begin errors++; $display("FAIL inorder_frame_done p=%0d got %b want %b", p, frame_done, p == 7); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.pix_ready = 1'b0;
    wait_cv(ok);
    checks++;
    if (!ok || bus.xpixel_check !== 32'd0 || bus.ypixel_check !== 32'd0)
      begin errors++; $display("FAIL bp_coord got (%0d,%0d) want (0,0)", bus.xpixel_check, bus.ypixel_check); end
    answer(4'b0010, 24'h00ABCD);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_colour !== 24'h01ABCD || bus.pix_sof !== 1'b1 ||
          bus.pix_eol !== 1'b0 || bus.check_valid !== 1'b0 || bus.xpixel_check !== 32'd0)
        begin errors++; $display("FAIL bp_hold k=%0d pv=%b col=%h sof=%b cv=%b x=%0d want col=01abcd", k,
          bus.pix_valid, bus.pix_colour, bus.pix_sof, bus.check_valid, bus.xpixel_check); end
      step();
    end
    bus.pix_ready = 1'b1;
    step();
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.check_valid !== 1'b1 || bus.xpixel_check !== 32'd1 ||
        bus.ypixel_check !== 32'd0)
      begin errors++; $display("FAIL bp_accept pv=%b cv=%b got (%0d,%0d) want (1,0)", bus.pix_valid,
        bus.check_valid, bus.xpixel_check, bus.ypixel_check); end
    checks++;
    if (fd_cnt !== 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", fd_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    checks++;
    if (drop_count !== 16'd0) begin errors++; $display("FAIL drop_before got %0d want 0", drop_count); end
    for (int k = 0; k < 7; k++) begin
      step();
      checks++;
      if (bus.check_valid !== 1'b1 || bus.pix_valid !== 1'b0)
        begin errors++; $display("FAIL timeout_early k=%0d cv=%b pv=%b", k, bus.check_valid, bus.pix_valid); end
    end
    step();
    checks++;
    if (bus.pix_valid !== 1'b1 || bus.pix_colour !== FILL || drop_count !== 16'd1 ||
        bus.pix_sof !== 1'b0 || bus.pix_eol !== 1'b0)
      begin errors++; $display("FAIL timeout_fill pv=%b col=%h drop=%0d want col=ff00ff drop=1",
        bus.pix_valid, bus.pix_colour, drop_count); end
    step();
    wait_cv(ok);
    checks++;
    if (!ok || bus.xpixel_check !== 32'd2 || bus.ypixel_check !== 32'd0)
      begin errors++; $display("FAIL timeout_next got (%0d,%0d) want (2,0)", bus.xpixel_check, bus.ypixel_check); end
  endtask

  task automatic test_hit_on_timeout();
    for (int k = 0; k < 7; k++) step();
    bus.lane_hit = 4'b0100;
    for (int i = 0; i < NL; i++) bus.lane_colour[i] = {8'(i), 16'h7777};
    step();
    bus.lane_hit = '0;
    checks++;
    if (bus.pix_valid !== 1'b1 || bus.pix_colour !== 24'h027777 || drop_count !== 16'd1)
      begin errors++; $display("FAIL hit_on_timeout pv=%b col=%h drop=%0d want col=027777 drop=1",
        bus.pix_valid, bus.pix_colour, drop_count); end
    step();
  endtask

  task automatic test_multi_hit();
    bit ok;
    checks++;
    if (err_multi_hit !== 1'b0) begin errors++; $display("FAIL err_before got %b want 0", err_multi_hit); end
    wait_cv(ok);
    checks++;
    if (!ok || bus.xpixel_check !== 32'd3 || bus.ypixel_check !== 32'd0)
      begin errors++; $display("FAIL multi_coord got (%0d,%0d) want (3,0)", bus.xpixel_check, bus.ypixel_check); end
    answer(4'b0110, 24'h004242);
    checks++;
    if (bus.pix_colour !== 24'h014242 || err_multi_hit !== 1'b1 || bus.pix_eol !== 1'b1)
      begin errors++; $display("FAIL multi_hit col=%h err=%b eol=%b want col=014242 err=1 eol=1",
        bus.pix_colour, err_multi_hit, bus.pix_eol); end
    step();
    wait_cv(ok);
    checks++;
    if (!ok || bus.xpixel_check !== 32'd0 || bus.ypixel_check !== 32'd1)
      begin errors++; $display("FAIL wrap_coord got (%0d,%0d) want (0,1)", bus.xpixel_check, bus.ypixel_check); end
    answer(4'b0001, 24'h000101);
    checks++;
    if (bus.pix_colour !== 24'h000101 || err_multi_hit !== 1'b1)
      begin errors++; $display("FAIL err_sticky col=%h err=%b want col=000101 err=1", bus.pix_colour, err_multi_hit); end
    step();
  endtask

  task automatic test_reset_run();
    bit ok;
    for (int xx = 1; xx < 3; xx++) begin
      wait_cv(ok);
      checks++;
      if (!ok || bus.xpixel_check !== 32'(xx) || bus.ypixel_check !== 32'd1)
        begin errors++; $display("FAIL line1_coord got (%0d,%0d) want (%0d,1)", bus.xpixel_check,
          bus.ypixel_check, xx); end
      answer(4'b1000, 24'h00CC00);
      checks++;
      if (bus.pix_colour !== 24'h03CC00)
        begin errors++; $display("FAIL line1_colour got %h want 03cc00", bus.pix_colour); end
      step();
    end
    run = 1'b0;
    wait_cv(ok);
    answer(4'b0001, 24'h000F0F);
    checks++;
    if (bus.pix_valid !== 1'b1 || bus.pix_eol !== 1'b1 || bus.pix_colour !== 24'h000F0F)
      begin errors++; $display("FAIL last_pixel pv=%b eol=%b col=%h", bus.pix_valid, bus.pix_eol, bus.pix_colour); end
    step();
    checks++;
    if (frame_done !== 1'b1 || bus.check_valid !== 1'b0)
      begin errors++; $display("FAIL stop_at_end fd=%b cv=%b want fd=1 cv=0", frame_done, bus.check_valid); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.check_valid !== 1'b0 || bus.pix_valid !== 1'b0)
        begin errors++; $display("FAIL idle_hold k=%0d cv=%b pv=%b", k, bus.check_valid, bus.pix_valid); end
    end
    run = 1'b1;
    step();
    wait_cv(ok);
    checks++;
    if (!ok || bus.xpixel_check !== 32'd0 || bus.ypixel_check !== 32'd0)
      begin errors++; $display("FAIL restart_coord got (%0d,%0d) want (0,0)", bus.xpixel_check, bus.ypixel_check); end
    bus.pix_ready = 1'b0;
    answer(4'b1000, 24'h001234);
    checks++;
    if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_wait pv=%b want 1", bus.pix_valid); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.pix_colour !== 24'h0 || bus.pix_sof !== 1'b0 ||
        bus.pix_eol !== 1'b0 || bus.check_valid !== 1'b0 || frame_done !== 1'b0 ||
        drop_count !== 16'd0 || err_multi_hit !== 1'b0)
      begin errors++; $display("FAIL async_reset pv=%b col=%h cv=%b drop=%0d err=%b", bus.pix_valid,
        bus.pix_colour, bus.check_valid, drop_count, err_multi_hit); end
    run = 1'b0;
    step();
    reset = 1'b1;
    step(); step();
    bus.lane_hit = 4'b0001;
    step();
    bus.lane_hit = '0;
    checks++;
    if (err_multi_hit !== 1'b1 || bus.check_valid !== 1'b0 || bus.pix_valid !== 1'b0)
      begin errors++; $display("FAIL hit_outside_scan err=%b cv=%b pv=%b want err=1 cv=0 pv=0",
        err_multi_hit, bus.check_valid, bus.pix_valid); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_timeout();
    test_hit_on_timeout();
    test_multi_hit();
    test_reset_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
